// File: rtl/m_frame_tx.sv
// Byte-frame transmitter: buffers host words into committed frames and sends
// each as SYNC + 16-bit word count + payload, NRZ or Manchester, MSB first.
module m_frame_tx #(
  parameter int         DATA_W        = 8,
  parameter int         DEPTH         = 64,
  parameter int         MAX_FRAMES    = 8,
  parameter int         HALF_BIT_CLKS = 1,
  parameter int         MANCHESTER    = 1,
  parameter logic [7:0] SYNC_WORD     = 8'hD5,
  parameter int         GAP_BITS      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_we,
  input  logic              i_push_frame,
  input  logic              i_clr_status,
  output logic [15:0]       o_data_size,
  output logic [7:0]        o_frames_count,
  output logic [7:0]        o_status,
  output logic              o_busy,
  output logic              o_tx,
  output logic [2:0]        o_dbg_state
);

  localparam int AW      = $clog2(DEPTH);
  localparam int FW      = $clog2(MAX_FRAMES);
  localparam int SH_W    = (DATA_W > 16) ? DATA_W : 16;
  localparam int BC_MAX  = (GAP_BITS > SH_W) ? GAP_BITS : SH_W;
  localparam int BCW     = $clog2(BC_MAX + 1);
  localparam int HW      = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;

  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [FW:0]   MF_C      = (FW + 1)'(MAX_FRAMES);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  // Host side has no backpressure: a write or push strobe is taken every
  // cycle it is high; anything that cannot be honoured is dropped and flagged.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [15:0]       lf_mem [MAX_FRAMES];

  logic [AW:0] wr_ptr, commit_ptr, rd_ptr;
  logic [AW:0] occ, open_len;
  logic [FW:0] lf_wr, lf_rd, lf_cnt;
  logic        push_q;
  logic [7:0]  frames_cnt;
  logic        ovf_st, epush_st, ffpush_st;

  logic full, empty, lf_full;
  logic we_ok, ovf_evt, push_zero, push_ff, push_ok;

  state_t          state, state_d;
  logic [HW-1:0]   half_cnt, half_cnt_d;
  logic            phase, phase_d;
  logic [BCW-1:0]  bit_cnt, bit_cnt_d;
  logic [SH_W-1:0] shreg, shreg_d;
  logic [15:0]     len_reg, len_d;
  logic [15:0]     words_left, words_left_d;
  logic            tx_q, tx_next;
  logic            half_end, bit_end;
  logic            start_frame, lf_pop, rd_adv, frame_done;

  assign occ      = wr_ptr - rd_ptr;
  assign open_len = wr_ptr - commit_ptr;
  assign lf_cnt   = lf_wr - lf_rd;
  assign full     = (occ == DEPTH_C);
  assign empty    = (occ == '0);
  assign lf_full  = (lf_cnt == MF_C);

  assign we_ok     = i_data_we & ~full;
  assign ovf_evt   = i_data_we & full;
  // The push strobe is registered, so the committed length covers every word
  // written up to and including the cycle the strobe was high.
  assign push_zero = push_q & (open_len == '0);
  assign push_ff   = push_q & ~push_zero & lf_full;
  assign push_ok   = push_q & ~push_zero & ~lf_full;

  assign half_end = (half_cnt == HALF_LAST);
  assign bit_end  = half_end & phase;

  always_comb begin
    state_d      = state;
    half_cnt_d   = half_cnt;
    phase_d      = phase;
    bit_cnt_d    = bit_cnt;
    shreg_d      = shreg;
    len_d        = len_reg;
    words_left_d = words_left;
    start_frame  = 1'b0;
    lf_pop       = 1'b0;
    rd_adv       = 1'b0;
    frame_done   = 1'b0;
    tx_next      = 1'b0;

    if (state == S_IDLE) begin
      start_frame = (frames_cnt != 8'd0);
    end else begin
      half_cnt_d = half_end ? '0 : half_cnt + 1'b1;
      if (half_end) phase_d = ~phase;
      if (bit_end) begin
        shreg_d   = shreg << 1;
        bit_cnt_d = bit_cnt - 1'b1;
        if (bit_cnt == BCW'(1)) begin
          case (state)
            S_SYNC: begin
              state_d   = S_LEN;
              shreg_d   = SH_W'(len_reg) << (SH_W - 16);
              bit_cnt_d = BCW'(16);
            end
            S_LEN: begin
              state_d      = S_DATA;
              shreg_d      = SH_W'(mem[rd_ptr[AW-1:0]]) << (SH_W - DATA_W);
              rd_adv       = 1'b1;
              words_left_d = len_reg - 16'd1;
              bit_cnt_d    = BCW'(DATA_W);
            end
            S_DATA: begin
              if (words_left != 16'd0) begin
                shreg_d      = SH_W'(mem[rd_ptr[AW-1:0]]) << (SH_W - DATA_W);
                rd_adv       = 1'b1;
                words_left_d = words_left - 16'd1;
                bit_cnt_d    = BCW'(DATA_W);
              end else begin
                state_d    = S_GAP;
                bit_cnt_d  = BCW'(GAP_BITS);
                frame_done = 1'b1;
              end
            end
            S_GAP: begin
              if (frames_cnt != 8'd0) start_frame = 1'b1;
              else state_d = S_IDLE;
            end
            default: ;
          endcase
        end
      end
    end

    // A new frame may start from IDLE or straight out of the last gap bit.
    if (start_frame) begin
      state_d    = S_SYNC;
      lf_pop     = 1'b1;
      len_d      = lf_mem[lf_rd[FW-1:0]];
      shreg_d    = SH_W'(SYNC_WORD) << (SH_W - 8);
      bit_cnt_d  = BCW'(8);
      half_cnt_d = '0;
      phase_d    = 1'b0;
    end

    if (state_d == S_SYNC || state_d == S_LEN || state_d == S_DATA) begin
      if (MANCHESTER != 0) tx_next = phase_d ? shreg_d[SH_W-1] : ~shreg_d[SH_W-1];
      else tx_next = shreg_d[SH_W-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      half_cnt   <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      len_reg    <= '0;
      words_left <= '0;
      tx_q       <= 1'b0;
    end else begin
      state      <= state_d;
      half_cnt   <= half_cnt_d;
      phase      <= phase_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      len_reg    <= len_d;
      words_left <= words_left_d;
      tx_q       <= tx_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      lf_wr      <= '0;
      lf_rd      <= '0;
      push_q     <= 1'b0;
      frames_cnt <= 8'd0;
      ovf_st     <= 1'b0;
      epush_st   <= 1'b0;
      ffpush_st  <= 1'b0;
    end else begin
      push_q <= i_push_frame;
      if (we_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push_ok) begin
        lf_wr      <= lf_wr + 1'b1;
        commit_ptr <= wr_ptr;
      end
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      if (lf_pop) lf_rd <= lf_rd + 1'b1;
      case ({push_ok, frame_done})
        2'b10:   frames_cnt <= frames_cnt + 8'd1;
        2'b01:   frames_cnt <= frames_cnt - 8'd1;
        default: ;
      endcase
      // A fresh event outranks a clear in the same cycle.
      ovf_st    <= ovf_evt | (ovf_st & ~i_clr_status);
      epush_st  <= push_zero | (epush_st & ~i_clr_status);
      ffpush_st <= push_ff | (ffpush_st & ~i_clr_status);
    end
  end

  always_ff @(posedge i_clk) begin
    if (we_ok) mem[wr_ptr[AW-1:0]] <= i_data;
    if (push_ok) lf_mem[lf_wr[FW-1:0]] <= 16'(open_len);
  end

  assign o_busy         = (state != S_IDLE);
  assign o_tx           = tx_q;
  assign o_data_size    = 16'(open_len);
  assign o_frames_count = frames_cnt;
  assign o_status       = {1'b0, ffpush_st, o_busy, epush_st, ovf_st, lf_full, empty, full};
  assign o_dbg_state    = state;

endmodule
